timing_nco: RTL

Fixed-point modulo-1 decrementing NCO and interpolation controller for the MSK symbol-timing recovery loop. It sits directly downstream of the timing loop filter and consumes its signed control word. It produces the interpolation strobe and fractional interval mu for the fractional-delay interpolator. It also flags which strobes are on-time versus mid-symbol, so the Gardner TED knows when to compute an error.

---
 rtl/msk_timing_pkg.sv | 18 +
 rtl/timing_mu_calc.sv | 41 ++++
 rtl/timing_nco.sv | 113 +++++++++++
 3 files changed

// File: rtl/msk_timing_pkg.sv
// Shared types and helpers for the MSK symbol-timing recovery path (NCO, interpolator).
package msk_timing_pkg;

    localparam int unsigned NCO_W_DEF  = 24;
    localparam int unsigned MU_W_DEF   = 16;
    localparam int unsigned CTRL_W_DEF = 16;

    typedef logic [NCO_W_DEF-1:0] eta_t;
    typedef logic [MU_W_DEF-1:0]  mu_t;

    // Unsigned saturating resize: clamp value to the largest number representable in width bits.
    function automatic logic [63:0] sat_resize(input logic [63:0] value, input int unsigned width);
        logic [63:0] max_val;
        max_val = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
        return (value > max_val) ? max_val : value;
    endfunction

endpackage

// File: rtl/timing_mu_calc.sv
// Registered conversion of the underflowed NCO residue into the fractional interval mu.
module timing_mu_calc
    import msk_timing_pkg::*;
#(
    parameter int unsigned           NCO_W      = NCO_W_DEF,
    parameter int unsigned           RECIP_W    = 16,
    parameter int unsigned           RECIP_FRAC = 12,
    parameter int unsigned           MU_W       = MU_W_DEF,
    parameter logic [RECIP_W-1:0]    NOM_RECIP  = 16'h2000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [NCO_W-1:0] eta,
    output logic [MU_W-1:0]  mu
);

    localparam int unsigned SHIFT = NCO_W + RECIP_FRAC - MU_W;

    logic [NCO_W+RECIP_W-1:0] product;
    logic [63:0]              scaled;
    logic [MU_W-1:0]          mu_d;
    logic [MU_W-1:0]          mu_q;

    always_comb begin
        product = {{RECIP_W{1'b0}}, eta} * {{NCO_W{1'b0}}, NOM_RECIP};
        scaled  = 64'(product) >> SHIFT;
        mu_d    = MU_W'(sat_resize(scaled, MU_W));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mu_q <= '0;
        end else if (load) begin
            mu_q <= mu_d;
        end
    end

    assign mu = mu_q;

endmodule

// File: rtl/timing_nco.sv
// Modulo-1 decrementing NCO driving interpolation strobes, mu and on-time flags for the Gardner TED.
module timing_nco
    import msk_timing_pkg::*;
#(
    parameter int unsigned          NCO_W      = NCO_W_DEF,
    parameter int unsigned          CTRL_W     = CTRL_W_DEF,
    parameter int unsigned          CTRL_SHIFT = 8,
    parameter logic [NCO_W-1:0]     NOM_STEP   = 24'h800000,
    parameter logic [NCO_W-1:0]     STEP_MIN   = 24'h600000,
    parameter logic [NCO_W-1:0]     STEP_MAX   = 24'hA00000,
    parameter int unsigned          RECIP_W    = 16,
    parameter int unsigned          RECIP_FRAC = 12,
    parameter logic [RECIP_W-1:0]   NOM_RECIP  = 16'h2000,
    parameter int unsigned          MU_W       = MU_W_DEF,
    parameter logic [NCO_W-1:0]     RESET_ETA  = 24'h000000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sample_valid_i,
    input  logic              ctrl_valid_i,
    input  logic [CTRL_W-1:0] ctrl_i,
    output logic              strobe_o,
    output logic [MU_W-1:0]   mu_o,
    output logic              on_time_o,
    output logic [NCO_W-1:0]  step_o,
    output logic              step_clamped_o
);

    localparam int unsigned SUM_W = NCO_W + 2;

    logic [CTRL_W-1:0]       ctrl_q;
    logic [NCO_W-1:0]        eta_q, eta_d;
    logic                    phase_q;
    logic                    strobe_q;
    logic                    on_time_q;
    logic [NCO_W-1:0]        step_q;
    logic                    clamped_q;

    logic signed [SUM_W-1:0] ctrl_shifted;
    logic signed [SUM_W-1:0] step_sum;
    logic [NCO_W-1:0]        step_eff;
    logic                    clamp_hit;
    logic                    fire;

    // Step is derived combinationally from ctrl_q, so a control word loaded alongside a sample
    // only affects the following sample; step_o is the registered debug view of it.
    always_comb begin
        ctrl_shifted = $signed({{(SUM_W-CTRL_W){ctrl_q[CTRL_W-1]}}, ctrl_q}) <<< CTRL_SHIFT;
        step_sum     = $signed({2'b00, NOM_STEP}) + ctrl_shifted;
        step_eff     = step_sum[NCO_W-1:0];
        clamp_hit    = 1'b0;
        if (step_sum < $signed({2'b00, STEP_MIN})) begin
            step_eff  = STEP_MIN;
            clamp_hit = 1'b1;
        end else if (step_sum > $signed({2'b00, STEP_MAX})) begin
            step_eff  = STEP_MAX;
            clamp_hit = 1'b1;
        end
    end

    // Wraparound subtraction covers both the plain and underflow cases modulo 2^NCO_W.
    always_comb begin
        fire  = sample_valid_i && (eta_q < step_eff);
        eta_d = eta_q;
        if (sample_valid_i) begin
            eta_d = eta_q - step_eff;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl_q    <= '0;
            eta_q     <= RESET_ETA;
            phase_q   <= 1'b0;
            strobe_q  <= 1'b0;
            on_time_q <= 1'b0;
            step_q    <= NOM_STEP;
            clamped_q <= 1'b0;
        end else begin
            if (ctrl_valid_i) begin
                ctrl_q <= ctrl_i;
            end
            eta_q     <= eta_d;
            strobe_q  <= fire;
            on_time_q <= fire & phase_q;
            if (fire) begin
                phase_q <= ~phase_q;
            end
            step_q    <= step_eff;
            clamped_q <= clamp_hit;
        end
    end

    timing_mu_calc #(
        .NCO_W      (NCO_W),
        .RECIP_W    (RECIP_W),
        .RECIP_FRAC (RECIP_FRAC),
        .MU_W       (MU_W),
        .NOM_RECIP  (NOM_RECIP)
    ) u_mu_calc (
        .clk   (clk),
        .reset (reset),
        .load  (fire),
        .eta   (eta_q),
        .mu    (mu_o)
    );

    assign strobe_o       = strobe_q;
    assign on_time_o      = on_time_q;
    assign step_o         = step_q;
    assign step_clamped_o = clamped_q;

endmodule
